// File: rtl/input_frame_loader_pkg.sv
// Shared constants and types for the convolution front end: frame geometry,
// loader FSM encoding and ui_in button bit positions.
package conv_pkg;

  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 6;
  localparam int unsigned FRAME_W = ROWS * COLS;

  localparam int unsigned LOAD_BTN = 6;
  localparam int unsigned GO_BTN   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    SEND = 2'd3
  } loader_state_t;

endpackage

// File: rtl/input_frame_loader_if.sv
// Valid/ready frame channel between the input loader and the convolution layer.
interface input_frame_loader_if;
  import conv_pkg::*;

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);

endinterface

// File: rtl/input_frame_loader_button.sv
// Button conditioner: 2-flop synchronizer, debounce counter and a one-cycle
// pulse on the rising edge of the debounced level.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic       sync1, sync2;
  logic       level, level_q;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        // The increment that would reach DEBOUNCE_CYCLES commits the new level instead.
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Combinational edge detect keeps press latency at DEBOUNCE_CYCLES+3 edges.
  assign pulse = level & ~level_q;

endmodule

// File: rtl/input_frame_loader.sv
// Input frame loader: conditions load/go buttons, assembles six 6-bit rows
// into a 36-bit frame and offers it downstream over valid/ready.
module input_frame_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ROWS            = conv_pkg::ROWS,
  parameter int unsigned COLS            = conv_pkg::COLS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  ui_in,
  input_frame_loader_if.master        frame,
  output logic [2:0]                  row_count,
  output logic                        loading,
  output logic                        overflow_err,
  output logic                        short_err
);
  import conv_pkg::*;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  logic               load_p, go_p;
  logic [COLS-1:0]    row_s1, row_s2;
  loader_state_t      state;
  logic [FRAME_W-1:0] frame_q;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (ui_in[LOAD_BTN]),
    .pulse (load_p)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (ui_in[GO_BTN]),
    .pulse (go_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= ui_in[COLS-1:0];
      row_s2 <= row_s1;
    end
  end

  // Load has priority over go in every state; go in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_q      <= '0;
      row_count    <= '0;
      overflow_err <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_p) begin
            frame_q[COLS-1:0] <= row_s2;
            row_count         <= 3'd1;
            state             <= FILL;
          end else if (go_p) begin
            short_err <= 1'b1;
          end
        end
        FILL: begin
          if (load_p) begin
            frame_q[int'(row_count)*COLS +: COLS] <= row_s2;
            row_count <= row_count + 3'd1;
            if (row_count == LAST_ROW) state <= FULL;
          end else if (go_p) begin
            short_err <= 1'b1;
          end
        end
        FULL: begin
          if (load_p) begin
            overflow_err <= 1'b1;
          end else if (go_p) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (load_p) overflow_err <= 1'b1;
          if (frame.frame_ready) begin
            frame_q   <= '0;
            row_count <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame.frame_data  = frame_q;
  assign frame.frame_valid = (state == SEND);
  assign loading           = (state == FILL);

endmodule

// File: tb/tb_input_frame_loader.sv
// Directed bench for input_frame_loader with DEBOUNCE_CYCLES=4.
module tb_input_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [2:0]  row_count;
  logic        loading, overflow_err, short_err;
  int          errors = 0;
  int          checks = 0;

  input_frame_loader_if fif ();

  input_frame_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ui_in        (ui_in),
    .frame        (fif.master),
    .row_count    (row_count),
    .loading      (loading),
    .overflow_err (overflow_err),
    .short_err    (short_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ui_in = 8'h00;
    fif.frame_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Clean load press: data set up early, press held 9 edges, release debounced.
  task automatic press_load(input logic [5:0] row);
    ui_in[5:0] = row;
    tick(3);
    ui_in[6] = 1'b1;
    tick(9);
    ui_in[6] = 1'b0;
    tick(8);
  endtask

  // Go press that also counts valid cycles and captures the data seen while valid.
  task automatic press_go(output int vcount, output logic [35:0] vdata);
    vcount = 0;
    vdata  = '0;
    ui_in[7] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (fif.frame_valid) begin vcount++; vdata = fif.frame_data; end
    end
    ui_in[7] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (fif.frame_valid) begin vcount++; vdata = fif.frame_data; end
    end
  endtask

  function automatic logic [35:0] pack6(input logic [5:0] r0, r1, r2, r3, r4, r5);
    logic [35:0] f;
    f = {r5, r4, r3, r2, r1, r0};
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ui_in = 8'h00;
    fif.frame_ready = 1'b0;
    tick(3);
    checks++; if (fif.frame_data !== 36'h0) begin errors++; $display("FAIL reset_data got %h want 0", fif.frame_data); end
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fif.frame_valid); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL reset_row_count got %0d want 0", row_count); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b want 0", loading); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_err); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL reset_short got %b want 0", short_err); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_frame();
    logic [5:0] rows [6];
    do_reset();
    rows = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    for (int r = 0; r < 6; r++) begin
      press_load(rows[r]);
      checks++; if (row_count !== 3'(r + 1)) begin errors++; $display("FAIL basic_row_count[%0d] got %0d want %0d", r, row_count, r + 1); end
    end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL basic_loading_full got %b want 0", loading); end
    checks++; if (fif.frame_data !== 36'h810204081) begin errors++; $display("FAIL basic_frame got %h want 810204081", fif.frame_data); end
    fif.frame_ready = 1'b1;
    // Go latency: valid appears exactly 7 edges after go is first sampled high.
    ui_in[7] = 1'b1;
    tick(6);
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b want 0", fif.frame_valid); end
    tick(1);
    checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got %b want 1", fif.frame_valid); end
    checks++; if (fif.frame_data !== 36'h810204081) begin errors++; $display("FAIL basic_valid_data got %h want 810204081", fif.frame_data); end
    tick(1);
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", fif.frame_valid); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL basic_cleared_count got %0d want 0", row_count); end
    checks++; if (fif.frame_data !== 36'h0) begin errors++; $display("FAIL basic_cleared_data got %h want 0", fif.frame_data); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL basic_idle_loading got %b want 0", loading); end
    ui_in[7] = 1'b0;
    tick(10);
    fif.frame_ready = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset();
    ui_in[5:0] = 6'h15;
    tick(3);
    for (int i = 0; i < 40; i++) begin
      ui_in[6] = ((i % 4) != 3);
      tick(1);
    end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL bounce_reject got %0d want 0", row_count); end
    ui_in[6] = 1'b1;
    tick(6);
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL bounce_edge6 got %0d want 0", row_count); end
    tick(1);
    checks++; if (row_count !== 3'd1) begin errors++; $display("FAIL bounce_edge7 got %0d want 1", row_count); end
    checks++; if (fif.frame_data !== 36'h15) begin errors++; $display("FAIL bounce_row0 got %h want 15", fif.frame_data); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL bounce_loading got %b want 1", loading); end
    tick(3);
    ui_in[6] = 1'b0;
    tick(10);
  endtask

  task automatic test_long_press();
    do_reset();
    ui_in[5:0] = 6'h3F;
    tick(3);
    ui_in[6] = 1'b1;
    tick(200);
    ui_in[6] = 1'b0;
    tick(10);
    checks++; if (row_count !== 3'd1) begin errors++; $display("FAIL long_press_count got %0d want 1", row_count); end
    checks++; if (fif.frame_data !== 36'h3F) begin errors++; $display("FAIL long_press_data got %h want 3f", fif.frame_data); end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    int          waited;
    do_reset();
    exp = pack6(6'h11, 6'h22, 6'h33, 6'h04, 6'h15, 6'h2A);
    press_load(6'h11); press_load(6'h22); press_load(6'h33);
    press_load(6'h04); press_load(6'h15); press_load(6'h2A);
    checks++; if (fif.frame_data !== exp) begin errors++; $display("FAIL bp_frame got %h want %h", fif.frame_data, exp); end
    ui_in[7] = 1'b1;
    waited = 0;
    while (fif.frame_valid !== 1'b1 && waited < 20) begin tick(1); waited++; end
    checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b want 1", fif.frame_valid); end
    ui_in[7] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (fif.frame_valid !== 1'b1 || fif.frame_data !== exp) begin
        errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%h want valid=1 data=%h", i, fif.frame_valid, fif.frame_data, exp);
      end
    end
    press_load(6'h3F);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow_err); end
    checks++; if (row_count !== 3'd6) begin errors++; $display("FAIL bp_count got %0d want 6", row_count); end
    checks++; if (fif.frame_valid !== 1'b1 || fif.frame_data !== exp) begin
      errors++; $display("FAIL bp_after_load got valid=%b data=%h want valid=1 data=%h", fif.frame_valid, fif.frame_data, exp);
    end
    fif.frame_ready = 1'b1;
    tick(1);
    checks++; if (fif.frame_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake got %b want 0", fif.frame_valid); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL bp_cleared got %0d want 0", row_count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %b want 1", overflow_err); end
    fif.frame_ready = 1'b0;
  endtask

  task automatic test_short_go();
    int          vc;
    logic [35:0] vd, exp;
    do_reset();
    exp = pack6(6'h07, 6'h38, 6'h2D, 6'h12, 6'h09, 6'h30);
    press_load(6'h07); press_load(6'h38); press_load(6'h2D);
    fif.frame_ready = 1'b1;
    press_go(vc, vd);
    checks++; if (vc !== 0) begin errors++; $display("FAIL short_no_valid got %0d valid cycles want 0", vc); end
    checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", short_err); end
    checks++; if (row_count !== 3'd3) begin errors++; $display("FAIL short_count got %0d want 3", row_count); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL short_loading got %b want 1", loading); end
    press_load(6'h12); press_load(6'h09); press_load(6'h30);
    checks++; if (row_count !== 3'd6) begin errors++; $display("FAIL short_refill got %0d want 6", row_count); end
    press_go(vc, vd);
    checks++; if (vc !== 1) begin errors++; $display("FAIL short_send_pulse got %0d valid cycles want 1", vc); end
    checks++; if (vd !== exp) begin errors++; $display("FAIL short_send_data got %h want %h", vd, exp); end
    checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b want 1", short_err); end
    checks++; if (row_count !== 3'd0) begin errors++; $display("FAIL short_after_send got %0d want 0", row_count); end
    fif.frame_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    int waited;
    do_reset();
    for (int r = 0; r < 6; r++) press_load(6'(r + 1));
    ui_in[7] = 1'b1;
    waited = 0;
    while (fif.frame_valid !== 1'b1 && waited < 20) begin tick(1); waited++; end
    checks++; if (fif.frame_valid !== 1'b1) begin errors++; $display("FAIL rst_send_timeout got %b want 1", fif.frame_valid); end
    ui_in[7] = 1'b0;
    // Force an error flag too so the reset has something sticky to clear.
    press_load(6'h01);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL rst_pre_overflow got %b want 1", overflow_err); end
    rst = 1'b1;
    tick(1);
    checks++; if (fif.frame_valid !== 1'b0 || fif.frame_data !== 36'h0 || row_count !== 3'd0 ||
                  loading !== 1'b0 || overflow_err !== 1'b0 || short_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_send got valid=%b data=%h count=%0d loading=%b ovf=%b short=%b want all 0",
                         fif.frame_valid, fif.frame_data, row_count, loading, overflow_err, short_err);
    end
    rst = 1'b0;
    fif.frame_ready = 1'b1;
    tick(5);
    checks++; if (fif.frame_valid !== 1'b0 || row_count !== 3'd0) begin
      errors++; $display("FAIL rst_frame_discarded got valid=%b count=%0d want 0 0", fif.frame_valid, row_count);
    end
    fif.frame_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ui_in = 8'h00;
    fif.frame_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_bounce();
    test_long_press();
    test_backpressure();
    test_short_go();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
